// File: rtl/ul_idx_pkg.sv
// ============================================================================
// Module  : ul_idx_pkg
// Purpose : Shared mod-30 index constants and D/M/A widths for uplink index path
// Revision: 1.0
// ============================================================================
`default_nettype none

package ul_idx_pkg;

    localparam int MOD30       = 30;
    localparam int MOD30_MAX_M = 29;
    localparam int IDX_W       = 15;
    localparam int IDX_MAX     = 32767;

    // Widths shared with the div/mod-30 decomposer
    localparam int D_W  = 11;
    localparam int M_W  = 5;
    localparam int A_W  = IDX_W;
    localparam int A0_W = IDX_W + 1;

    typedef struct packed {
        logic [D_W-1:0] d;
        logic [M_W-1:0] m;
    } dm_t;

endpackage

`default_nettype wire

// File: rtl/ul_mul30_seq_if.sv
// ============================================================================
// Module  : ul_mul30_seq_if
// Purpose : Request/beat handshake bundle for the mod-30 recombiner
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ul_mul30_seq_if
    import ul_idx_pkg::*;
#(
    parameter int LEN_W = 8
);

    logic             req_vld;
    logic             req_rdy;
    logic [D_W-1:0]   req_d;
    logic [M_W-1:0]   req_m;
    logic [LEN_W-1:0] req_len;
    logic             out_vld;
    logic             out_rdy;
    logic [A_W-1:0]   out_a;
    logic [D_W-1:0]   out_d;
    logic [M_W-1:0]   out_m;
    logic             out_last;
    logic             err;
    logic             busy;

    // master: request source and beat consumer; slave: the recombiner
    modport master (
        output req_vld, req_d, req_m, req_len, out_rdy,
        input  req_rdy, out_vld, out_a, out_d, out_m, out_last, err, busy
    );

    modport slave (
        input  req_vld, req_d, req_m, req_len, out_rdy,
        output req_rdy, out_vld, out_a, out_d, out_m, out_last, err, busy
    );

endinterface

`default_nettype wire

// File: rtl/ul_mod30_inc.sv
// ============================================================================
// Module  : ul_mod30_inc
// Purpose : Combinational {d,m} step, m wraps 29->0 carrying into d
// Revision: 1.0
// ============================================================================
`default_nettype none

module ul_mod30_inc
    import ul_idx_pkg::*;
(
    input  dm_t cur,
    output dm_t nxt
);

    always_comb begin
        nxt = cur;
        if (cur.m == M_W'(MOD30_MAX_M)) begin
            nxt.m = '0;
            nxt.d = cur.d + D_W'(1);
        end else begin
            nxt.m = cur.m + M_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ul_mul30_seq.sv
// ============================================================================
// Module  : ul_mul30_seq
// Purpose : Walks a (D,M) mod-30 start point into consecutive linear indices
// Revision: 1.0
// ============================================================================
`default_nettype none

module ul_mul30_seq
    import ul_idx_pkg::*;
#(
    parameter int LEN_W = 8
)(
    input  wire logic     clk,
    input  wire logic     rstn,
    ul_mul30_seq_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [A0_W-1:0]  a0;
    logic             accept;
    logic             reject;
    logic             beat_done;
    logic [A_W-1:0]   cur_a;
    dm_t              cur_dm;
    dm_t              inc_dm;
    logic [LEN_W-1:0] rem;
    logic             last;
    logic             err;

    // 30*D = 32*D - 2*D; 16 bits holds the full D range so overflow is detectable
    assign a0 = (A0_W'(bus.req_d) << 5) - (A0_W'(bus.req_d) << 1) + A0_W'(bus.req_m);

    assign accept    = (state == ST_IDLE) && bus.req_vld;
    assign reject    = (bus.req_m >= M_W'(MOD30)) || (bus.req_len == '0)
                     || (a0 > A0_W'(IDX_MAX));
    assign beat_done = (state == ST_RUN) && bus.out_rdy;

    ul_mod30_inc u_inc (
        .cur (cur_dm),
        .nxt (inc_dm)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && !reject) state_nxt = ST_RUN;
            ST_RUN:  if (beat_done && last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_rdy = (state == ST_IDLE);
        bus.out_vld = (state == ST_RUN);
        bus.busy    = (state == ST_RUN);
    end

    // last is precomputed one step ahead so out_last comes straight from a flop
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_a  <= '0;
            cur_dm <= '0;
            rem    <= '0;
            last   <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                if (reject) begin
                    err <= 1'b1;
                end else begin
                    cur_a  <= a0[A_W-1:0];
                    cur_dm <= '{d: bus.req_d, m: bus.req_m};
                    rem    <= bus.req_len;
                    last   <= (bus.req_len == LEN_W'(1)) || (a0[A_W-1:0] == A_W'(IDX_MAX));
                end
            end else if (beat_done) begin
                if (last) begin
                    err  <= (rem != LEN_W'(1));
                    last <= 1'b0;
                end else begin
                    cur_a  <= cur_a + A_W'(1);
                    cur_dm <= inc_dm;
                    rem    <= rem - LEN_W'(1);
                    last   <= (rem == LEN_W'(2)) || (cur_a == A_W'(IDX_MAX - 1));
                end
            end
        end
    end

    assign bus.out_a    = cur_a;
    assign bus.out_d    = cur_dm.d;
    assign bus.out_m    = cur_dm.m;
    assign bus.out_last = last;
    assign bus.err      = err;

endmodule

`default_nettype wire

// File: tb/tb_ul_mul30_seq.sv
// ============================================================================
// Module  : tb_ul_mul30_seq
// Purpose : Self-checking bench for ul_mul30_seq against an arithmetic model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ul_mul30_seq;

    localparam int LEN_W = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ul_mul30_seq_if #(.LEN_W(LEN_W)) bus ();

    ul_mul30_seq #(.LEN_W(LEN_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int a;
        int d;
        int m;
        bit last;
    } beat_t;

    beat_t beats[$];
    int    err_pulses   = 0;
    int    err_with_vld = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.out_vld && bus.out_rdy) begin
                beat_t b;
                b.a    = int'(bus.out_a);
                b.d    = int'(bus.out_d);
                b.m    = int'(bus.out_m);
                b.last = bus.out_last;
                beats.push_back(b);
            end
            if (bus.err) begin
                err_pulses++;
                if (bus.out_vld) err_with_vld++;
            end
        end
    end

    task automatic send(input int d, input int m, input int len);
        bus.req_d   = 11'(d);
        bus.req_m   = 5'(m);
        bus.req_len = LEN_W'(len);
        bus.req_vld = 1'b1;
        @(posedge clk); #1;
        bus.req_vld = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n, output bit done, output bit err_end);
        n = 0;
        done = 1'b0;
        err_end = 1'b0;
        while (n < budget && !done) begin
            @(negedge clk);
            n++;
            if (bus.req_rdy) begin
                done = 1'b1;
                err_end = bus.err;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        total++; if (bus.req_rdy !== 1'b1) begin bad++; $display("FAIL rst_req_rdy got %b want 1", bus.req_rdy); end
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL rst_out_vld got %b want 0", bus.out_vld); end
        total++; if (bus.out_a !== 15'd0 || bus.out_d !== 11'd0 || bus.out_m !== 5'd0) begin
            bad++; $display("FAIL rst_adm got %0d/%0d/%0d want 0/0/0", bus.out_a, bus.out_d, bus.out_m);
        end
        total++; if (bus.out_last !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rst_flags got last=%b err=%b busy=%b want 0", bus.out_last, bus.err, bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int exp_a[4] = '{88, 89, 90, 91};
        int exp_d[4] = '{2, 2, 3, 3};
        int exp_m[4] = '{28, 29, 0, 1};
        int n; bit done; bit e;
        beats.delete();
        bus.out_rdy = 1'b1;
        send(2, 28, 4);
        wait_idle(50, n, done, e);
        total++; if (!done || n != 5) begin bad++; $display("FAIL basic_ready_cycle got %0d want 5", n); end
        total++; if (beats.size() != 4) begin bad++; $display("FAIL basic_count got %0d want 4", beats.size()); end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            total++;
            if (beats[i].a != exp_a[i] || beats[i].d != exp_d[i] || beats[i].m != exp_m[i] || beats[i].last != (i == 3)) begin
                bad++;
                $display("FAIL basic_beat[%0d] got a=%0d d=%0d m=%0d last=%b want a=%0d d=%0d m=%0d last=%b",
                         i, beats[i].a, beats[i].d, beats[i].m, beats[i].last, exp_a[i], exp_d[i], exp_m[i], i == 3);
            end
        end
        total++; if (e) begin bad++; $display("FAIL basic_err got 1 want 0"); end
    endtask

    task automatic test_stall();
        bit rdy_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int exp_a[5]   = '{0, 1, 1, 1, 2};
        int n; bit done; bit e;
        send(0, 0, 3);
        for (int i = 0; i < 5; i++) begin
            bus.out_rdy = rdy_pat[i];
            @(negedge clk);
            total++;
            if (bus.out_vld !== 1'b1 || int'(bus.out_a) != exp_a[i] || int'(bus.out_m) != exp_a[i]
                || bus.out_d !== 11'd0 || bus.out_last !== (i == 4)) begin
                bad++;
                $display("FAIL stall_beat[%0d] got vld=%b a=%0d d=%0d m=%0d last=%b want vld=1 a=%0d d=0 m=%0d last=%b",
                         i, bus.out_vld, bus.out_a, bus.out_d, bus.out_m, bus.out_last, exp_a[i], exp_a[i], i == 4);
            end
            @(posedge clk); #1;
        end
        bus.out_rdy = 1'b1;
        wait_idle(10, n, done, e);
        total++; if (!done || n != 1) begin bad++; $display("FAIL stall_idle got n=%0d want 1", n); end
    endtask

    task automatic test_reject();
        int td[3] = '{5, 3, 1092};
        int tm[3] = '{30, 0, 8};
        int tl[3] = '{1, 0, 1};
        for (int k = 0; k < 3; k++) begin
            int e0 = err_pulses;
            int b0 = beats.size();
            bus.out_rdy = 1'b1;
            send(td[k], tm[k], tl[k]);
            @(negedge clk);
            total++;
            if (bus.err !== 1'b1 || bus.out_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin
                bad++; $display("FAIL reject[%0d]_pulse got err=%b vld=%b rdy=%b want 1/0/1", k, bus.err, bus.out_vld, bus.req_rdy);
            end
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if (bus.err !== 1'b0 || bus.out_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin
                bad++; $display("FAIL reject[%0d]_after got err=%b vld=%b rdy=%b want 0/0/1", k, bus.err, bus.out_vld, bus.req_rdy);
            end
            @(posedge clk); #1;
            total++;
            if (err_pulses - e0 != 1 || beats.size() != b0) begin
                bad++; $display("FAIL reject[%0d]_count got err=%0d beats=%0d want 1/0", k, err_pulses - e0, beats.size() - b0);
            end
        end
    endtask

    task automatic test_truncate();
        int n; bit done; bit e;
        beats.delete();
        bus.out_rdy = 1'b1;
        send(1092, 5, 10);
        wait_idle(50, n, done, e);
        total++; if (beats.size() != 3) begin bad++; $display("FAIL trunc_count got %0d want 3", beats.size()); end
        for (int i = 0; i < 3 && i < beats.size(); i++) begin
            total++;
            if (beats[i].a != 32765 + i || beats[i].d != 1092 || beats[i].m != 5 + i || beats[i].last != (i == 2)) begin
                bad++;
                $display("FAIL trunc_beat[%0d] got a=%0d d=%0d m=%0d last=%b want a=%0d d=1092 m=%0d last=%b",
                         i, beats[i].a, beats[i].d, beats[i].m, beats[i].last, 32765 + i, 5 + i, i == 2);
            end
        end
        total++; if (!done || !e) begin bad++; $display("FAIL trunc_err got done=%b err=%b want 1/1", done, e); end
        @(negedge clk);
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL trunc_err_width got %b want 0", bus.err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int n; bit done; bit e;
        bus.out_rdy = 1'b1;
        send(10, 3, 5);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (bus.out_vld !== 1'b0 || bus.busy !== 1'b0 || bus.req_rdy !== 1'b1 || bus.err !== 1'b0) begin
            bad++; $display("FAIL midrst_state got vld=%b busy=%b rdy=%b err=%b want 0/0/1/0",
                            bus.out_vld, bus.busy, bus.req_rdy, bus.err);
        end
        @(posedge clk); #1;
        beats.delete();
        send(1, 0, 1);
        wait_idle(20, n, done, e);
        total++;
        if (beats.size() != 1 || beats[0].a != 30 || beats[0].d != 1 || beats[0].m != 0 || !beats[0].last) begin
            bad++; $display("FAIL midrst_next got beats=%0d a=%0d want 1 beat a=30 last",
                            beats.size(), (beats.size() > 0) ? beats[0].a : -1);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            int a0    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(32767 - 300, 32767)) : int'($urandom_range(0, 32767));
            int len   = int'($urandom_range(1, 255));
            int room  = 32768 - a0;
            int n_exp = (len < room) ? len : room;
            int e0    = err_pulses;
            int cyc   = 0;
            bit done  = 1'b0;
            beats.delete();
            send(a0 / 30, a0 % 30, len);
            while (cyc < 3000 && !done) begin
                bus.out_rdy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                cyc++;
                if (bus.req_rdy) done = 1'b1;
                else begin @(posedge clk); #1; end
            end
            @(posedge clk); #1;
            total++; if (!done) begin bad++; $display("FAIL rand[%0d]_timeout got cyc=%0d want done", r, cyc); end
            total++;
            if (beats.size() != n_exp) begin
                bad++; $display("FAIL rand[%0d]_count got %0d want %0d (a0=%0d len=%0d)", r, beats.size(), n_exp, a0, len);
            end
            for (int i = 0; i < beats.size(); i++) begin
                total++;
                if (beats[i].a != a0 + i || beats[i].a != 30 * beats[i].d + beats[i].m || beats[i].m >= 30
                    || beats[i].last != (i == n_exp - 1)) begin
                    bad++;
                    $display("FAIL rand[%0d]_beat[%0d] got a=%0d d=%0d m=%0d last=%b want a=%0d last=%b",
                             r, i, beats[i].a, beats[i].d, beats[i].m, beats[i].last, a0 + i, i == n_exp - 1);
                end
            end
            total++;
            if (err_pulses - e0 != ((len > room) ? 1 : 0)) begin
                bad++; $display("FAIL rand[%0d]_err got %0d want %0d", r, err_pulses - e0, (len > room) ? 1 : 0);
            end
        end
        bus.out_rdy = 1'b1;
    endtask

    initial begin
        bus.req_vld = 1'b0;
        bus.req_d   = '0;
        bus.req_m   = '0;
        bus.req_len = '0;
        bus.out_rdy = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_reject();
        test_truncate();
        test_reset_mid_run();
        test_random();
        total++;
        if (err_with_vld != 0) begin bad++; $display("FAIL err_with_vld got %0d want 0", err_with_vld); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
